// File: rtl/sram_pkg.sv
// -----------------------------------------------------------------------------
// sram_pkg
// Shared types and constants for the SRAM wrapper's data-side OBI multiplexer.
//   obi_mst_e                  : master ID (core data port / SPI cache refill)
//   obi_req_t                  : OBI address-phase fields of one master
//   SRAM_D_MUX_MAX_OUTSTANDING : default number of granted-but-unanswered
//                                transactions the multiplexer will track
// -----------------------------------------------------------------------------
package sram_pkg;

  typedef enum logic {
    MST_CORE  = 1'b0,
    MST_CACHE = 1'b1
  } obi_mst_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_req_t;

  localparam int unsigned SRAM_D_MUX_MAX_OUTSTANDING = 2;

endpackage

// File: rtl/obi_id_fifo.sv
// -----------------------------------------------------------------------------
// obi_id_fifo
// Small FIFO of master IDs, one entry per granted OBI transaction still
// waiting for its rvalid. The head is read combinationally so responses can
// be routed in the same cycle they arrive.
// Ports:
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   push_i         : store push_id_i (ignored when full)
//   push_id_i      : ID of the master whose request was just granted
//   pop_i          : drop the head entry (ignored when empty)
//   full_o         : DEPTH entries held
//   empty_o        : no entries held
//   head_o         : ID of the oldest outstanding transaction
// -----------------------------------------------------------------------------
module obi_id_fifo
  import sram_pkg::*;
#(
  parameter int unsigned DEPTH = SRAM_D_MUX_MAX_OUTSTANDING,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     push_i,
  input  obi_mst_e push_id_i,
  input  logic     pop_i,
  output logic     full_o,
  output logic     empty_o,
  output obi_mst_e head_o
);

  localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);

  obi_mst_e         mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CNT_MAX);
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= MST_CORE;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_id_i;
        // Explicit wrap keeps non-power-of-two depths correct.
        wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/sram_d_obi_mux.sv
// -----------------------------------------------------------------------------
// sram_d_obi_mux
// Two-master to one-slave OBI multiplexer feeding the SRAM wrapper's data
// port. Master 0 is the core data port, master 1 the SPI cache refill port.
// Request and response paths are purely combinational; state is the
// address-phase lock, the round-robin pointer and the response-ID FIFO.
//
// Configuration macro: SRAM_D_MUX_FIXED_PRIO_EN
//   defined   : fixed priority, m0 over m1 (no round-robin pointer)
//   undefined : round-robin, pointer flips to the other master on handshake
//
// Ports:
//   clk_i, rst_i                  : clock, asynchronous active-high reset
//   mX_req_i / mX_gnt_o           : master X address-phase handshake
//   mX_addr_i/we_i/be_i/wdata_i   : master X request fields
//   mX_rvalid_o / mX_rdata_o      : master X response
//   sram_d_req_o / sram_d_gnt_i   : slave address-phase handshake
//   sram_d_addr_o/we_o/be_o/wdata_o : muxed request fields
//   sram_d_rvalid_i / rdata_i     : slave response
//   err_o                         : sticky, rvalid seen with nothing outstanding
// -----------------------------------------------------------------------------
module sram_d_obi_mux
  import sram_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = SRAM_D_MUX_MAX_OUTSTANDING,
  parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_req_i,
  output logic        m0_gnt_o,
  input  logic [31:0] m0_addr_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_be_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  input  logic        m1_req_i,
  output logic        m1_gnt_o,
  input  logic [31:0] m1_addr_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_be_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        sram_d_req_o,
  input  logic        sram_d_gnt_i,
  output logic [31:0] sram_d_addr_o,
  output logic        sram_d_we_o,
  output logic [3:0]  sram_d_be_o,
  output logic [31:0] sram_d_wdata_o,
  input  logic        sram_d_rvalid_i,
  input  logic [31:0] sram_d_rdata_i,
  output logic        err_o
);

  logic [1:0] req;
  obi_req_t   mreq [2];
  obi_req_t   fwd;
  logic [1:0] gnt;
  logic [1:0] rvalid;
  obi_mst_e   sel;
  obi_mst_e   tie_winner;
  obi_mst_e   fifo_head;
  obi_mst_e   lock_id_q;
  logic       lock_q;
  logic       err_q;
  logic       fifo_full;
  logic       fifo_empty;
  logic       req_out;
  logic       handshake;

  assign req     = {m1_req_i, m0_req_i};
  assign mreq[0] = '{addr: m0_addr_i, we: m0_we_i, be: m0_be_i, wdata: m0_wdata_i};
  assign mreq[1] = '{addr: m1_addr_i, we: m1_we_i, be: m1_be_i, wdata: m1_wdata_i};

`ifdef SRAM_D_MUX_FIXED_PRIO_EN
  assign tie_winner = MST_CORE;
`else
  obi_mst_e rr_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q <= MST_CORE;
    end else if (handshake) begin
      rr_q <= (sel == MST_CORE) ? MST_CACHE : MST_CORE;
    end
  end

  assign tie_winner = rr_q;
`endif

  // A locked address phase must stay on the same master until granted.
  always_comb begin
    sel = tie_winner;
    if (lock_q) begin
      sel = lock_id_q;
    end else if (req == 2'b01) begin
      sel = MST_CORE;
    end else if (req == 2'b10) begin
      sel = MST_CACHE;
    end
  end

  // No rvalid-to-req bypass: a full FIFO stalls even if it pops this cycle.
  assign req_out   = ~rst_i & req[sel] & ~fifo_full;
  assign handshake = req_out & sram_d_gnt_i;
  assign fwd       = rst_i ? '0 : mreq[sel];

  assign sram_d_req_o   = req_out;
  assign sram_d_addr_o  = fwd.addr;
  assign sram_d_we_o    = fwd.we;
  assign sram_d_be_o    = fwd.be;
  assign sram_d_wdata_o = fwd.wdata;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_mst
      assign gnt[gi]    = handshake & (logic'(sel) == 1'(gi));
      // A stray rvalid (FIFO empty) is dropped rather than routed.
      assign rvalid[gi] = ~rst_i & sram_d_rvalid_i & ~fifo_empty &
                          (logic'(fifo_head) == 1'(gi));
    end
  endgenerate

  assign m0_gnt_o    = gnt[0];
  assign m1_gnt_o    = gnt[1];
  assign m0_rvalid_o = rvalid[0];
  assign m1_rvalid_o = rvalid[1];
  assign m0_rdata_o  = sram_d_rdata_i;
  assign m1_rdata_o  = sram_d_rdata_i;
  assign err_o       = err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_q    <= 1'b0;
      lock_id_q <= MST_CORE;
    end else if (handshake) begin
      lock_q <= 1'b0;
    end else if (req_out) begin
      lock_q    <= 1'b1;
      lock_id_q <= sel;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (sram_d_rvalid_i & fifo_empty) begin
      err_q <= 1'b1;
    end
  end

  obi_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .CNT_W (CNT_W)
  ) u_id_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (handshake),
    .push_id_i (sel),
    .pop_i     (sram_d_rvalid_i),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .head_o    (fifo_head)
  );

endmodule

// File: doc/sram_d_obi_mux.md
# sram_d_obi_mux

Two-master to one-slave OBI multiplexer that drives the data-side port (`sram_d_*`) of the SRAM wrapper. It merges the core data port (master 0) and the SPI cache refill port (master 1), arbitrates between them, and tracks outstanding transactions. Returned `rvalid`/`rdata` are routed back to the master that issued each request, in order. The block adds zero cycles to the request and response paths; its state consists of the arbitration lock, the round-robin pointer and the response-ID FIFO.

## Interface
Parameters:
- `MAX_OUTSTANDING`, default 2: maximum granted-but-unanswered transactions; minimum 1.
- `CNT_W`, default `$clog2(MAX_OUTSTANDING+1)`: width of the occupancy counter.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `m0_req_i`, `m1_req_i`  in  1  master request.
- `m0_gnt_o`, `m1_gnt_o`  out  1  master grant.
- `m0_addr_i`, `m1_addr_i`  in  32  byte address.
- `m0_we_i`, `m1_we_i`  in  1  write enable.
- `m0_be_i`, `m1_be_i`  in  4  byte enables.
- `m0_wdata_i`, `m1_wdata_i`  in  32  write data.
- `m0_rvalid_o`, `m1_rvalid_o`  out  1  response valid.
- `m0_rdata_o`, `m1_rdata_o`  out  32  response data.
- `sram_d_req_o`  out  1  request to the SRAM wrapper.
- `sram_d_gnt_i`  in  1  grant from the SRAM wrapper.
- `sram_d_addr_o`, `sram_d_we_o`, `sram_d_be_o`, `sram_d_wdata_o`  out  32/1/4/32  muxed request fields.
- `sram_d_rvalid_i`  in  1  response valid.
- `sram_d_rdata_i`  in  32  response data.
- `err_o`  out  1  sticky protocol-error flag.

## Operation
- **Selection:** `sel` is chosen combinationally among requesting masters.
  - If `lock_q` is set, `sel = lock_id_q`.
  - Otherwise the master named by `rr_q` wins a tie.
- **Forwarding:**
  - `sram_d_req_o = req[sel] & ~full`.
  - Address, `we`, `be` and `wdata` are muxed from `sel`.
  - `m[sel]_gnt_o = sram_d_gnt_i & sram_d_req_o`; the other master's grant is 0.
- **Lock:**
  - Set when `sram_d_req_o & ~sram_d_gnt_i`; `lock_id_q` is set to `sel`.
  - Cleared on the handshake cycle.
  - This keeps the OBI address phase stable until it is granted.
- **Round-robin pointer:** on each handshake, `rr_q` is set to `~sel`.
- **Response-ID FIFO:**
  - Depth `MAX_OUTSTANDING`; each entry is 1 bit (the master ID).
  - Push `sel` on handshake; pop on `sram_d_rvalid_i`.
  - `full` when `count == MAX_OUTSTANDING`.
  - No `rvalid`-to-`req` bypass: a full FIFO stalls even if a pop happens in the same cycle.
  - Simultaneous push and pop leaves `count` unchanged; pointers wrap modulo depth.
- **Response routing:**
  - `m[head]_rvalid_o = sram_d_rvalid_i`.
  - Both `mX_rdata_o` carry `sram_d_rdata_i` unconditionally.
- **Error:** `sram_d_rvalid_i` while the FIFO is empty sets `err_o`. The response is dropped and `count` stays 0. `err_o` clears only on reset.
- **Reset mid-operation:** FIFO, lock and pointer are cleared; any pending responses are forgotten.

## Timing
- **Reset values:** `rr_q = 0` (m0 favoured), `lock_q = 0`, `count = 0`, `err_o = 0`.
- **While `rst_i` is high:**
  - `sram_d_req_o`, both grants and both rvalids are forced to 0.
  - `sram_d_addr_o`/`sram_d_wdata_o`/`sram_d_be_o`/`sram_d_we_o` are 0.
  - `mX_rdata_o` follows `sram_d_rdata_i`.
- **Request path:** combinational; request to `sram_d_req_o` takes 0 cycles.
- **Response path:** combinational; `sram_d_rvalid_i` to `mX_rvalid_o` takes 0 cycles. With the SRAM wrapper's same-cycle grant and next-cycle rvalid, master latency is 1 cycle.
- **Throughput:** with `MAX_OUTSTANDING` ≥ 2, back-to-back requests run at one per cycle. With 1, a new request can issue every other cycle.
- **Registered state:** `lock_q`, `lock_id_q`, `rr_q`, FIFO and `count` update on the rising edge of `clk_i`.

## Configuration
- Macro: `SRAM_D_MUX_FIXED_PRIO_EN`.
- **Defined:** fixed priority, m0 over m1. `rr_q` is not implemented, and the lock still applies.
- **Undefined (default):** round-robin as described under Operation.

## Structure
- Shared package `sram_pkg` holds:
  - `typedef enum logic {MST_CORE=0, MST_CACHE=1} obi_mst_e`;
  - `typedef struct packed {addr, we, be, wdata} obi_req_t`;
  - the `SRAM_D_MUX_MAX_OUTSTANDING` default constant.
- One sub-module, `obi_id_fifo`: a parameterised-depth FIFO of `obi_mst_e` with push/pop/full/empty/head outputs and asynchronous active-high reset.

## Test plan
- **Single-master reads:** m0 reads 0x8000_0010 twice back-to-back, SRAM wrapper returns 0x1111_2222 and 0x3333_4444 → `m0_rvalid_o` high one cycle after each grant with matching data; `m1_rvalid_o` stays 0.
- **Round-robin contention:** both masters request continuously for 4 cycles → grants go m0, m1, m0, m1. With `SRAM_D_MUX_FIXED_PRIO_EN` defined → m0, m0, m0, m0.
- **Lock under stall:** stub `gnt_i` held low for 3 cycles while m1 is selected, and m0 raises its request mid-stall → `sram_d_addr_o` stays at m1's address and m1 is granted first.
- **FIFO full:** `MAX_OUTSTANDING=2`, slave grants but delays rvalid 3 cycles → third request sees `sram_d_req_o=0` until the first rvalid, then issues. Responses route to the masters in order.
- **Protocol error:** `sram_d_rvalid_i` pulsed with the FIFO empty → `err_o` rises the next cycle and stays high; no master rvalid is asserted.
- **Reset mid-operation:** `rst_i` pulsed with 2 outstanding transactions → all outputs 0 during reset; afterwards `count = 0` and m0 wins the first tie.
